// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the 5-stage MIPS pipeline: opcode
//                constants, instruction-type codes, the fetch-queue FSM state
//                encoding and a next-PC helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Opcodes (instruction bits [31:26])
    localparam logic [5:0] c_OP_ADD   = 6'b000000;
    localparam logic [5:0] c_OP_SUB   = 6'b000001;
    localparam logic [5:0] c_OP_AND   = 6'b000010;
    localparam logic [5:0] c_OP_OR    = 6'b000011;
    localparam logic [5:0] c_OP_SLT   = 6'b000100;
    localparam logic [5:0] c_OP_MUL   = 6'b000101;
    localparam logic [5:0] c_OP_LW    = 6'b001000;
    localparam logic [5:0] c_OP_SW    = 6'b001001;
    localparam logic [5:0] c_OP_ADDI  = 6'b001010;
    localparam logic [5:0] c_OP_SUBI  = 6'b001011;
    localparam logic [5:0] c_OP_SLTI  = 6'b001100;
    localparam logic [5:0] c_OP_BNEQZ = 6'b001101;
    localparam logic [5:0] c_OP_BEQZ  = 6'b001110;
    localparam logic [5:0] c_OP_HLT   = 6'b111111;

    // Instruction-type codes
    localparam logic [2:0] c_TYPE_RR_ALU = 3'd0;
    localparam logic [2:0] c_TYPE_RM_ALU = 3'd1;
    localparam logic [2:0] c_TYPE_LOAD   = 3'd2;
    localparam logic [2:0] c_TYPE_STORE  = 3'd3;
    localparam logic [2:0] c_TYPE_BRANCH = 3'd4;
    localparam logic [2:0] c_TYPE_HALT   = 3'd5;

    // Fetch-queue state machine encoding
    typedef enum logic [1:0] {
        FQ_IDLE   = 2'd0,
        FQ_WAIT   = 2'd1,
        FQ_DRAIN  = 2'd2,
        FQ_HALTED = 2'd3
    } fq_state_t;

    // Next-PC of a fetched word: zero-extended word address plus one, in 32 bits
    function automatic logic [31:0] fq_next_pc(input logic [31:0] addr);
        return addr + 32'd1;
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/fq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fq_fifo
//  Description : Synchronous DEPTH x WIDTH FIFO with flush. Head is read
//                combinationally. Storage is cleared on reset so the head
//                reads zero out of reset.
//  Ports       : clk1, rst (async, active-high)
//                push/wdata   - write an entry (caller guarantees not full)
//                pop          - advance head (ignored when empty)
//                flush        - empty the FIFO, wins over push/pop
//                rdata        - head entry
//                count/full/empty - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module fq_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk1,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_CW'(DEPTH));
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + c_PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : fq_fifo
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction fetch front end ahead of decode. Issues one
//                outstanding req/ack fetch at a time, buffers {IR, NPC} in a
//                small FIFO and hands the head to decode via valid/ready.
//                Taken-branch redirects flush and refetch; halt stops issue.
//  Ports       : clk1, rst (async, active-high)
//                imem_req/imem_addr/imem_ack/imem_rdata - memory handshake
//                redirect/redirect_pc - branch redirect
//                halt                 - level, suppress new requests
//                id_valid/id_ir/id_npc/id_ready - decode handshake
//                count                - FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic                   clk1,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [AW-1:0]          imem_addr,
    input  logic                   imem_ack,
    input  logic [DW-1:0]          imem_rdata,
    input  logic                   redirect,
    input  logic [AW-1:0]          redirect_pc,
    input  logic                   halt,
    output logic                   id_valid,
    output logic [DW-1:0]          id_ir,
    output logic [31:0]            id_npc,
    input  logic                   id_ready,
    output logic [$clog2(DEPTH):0] count
);

    fq_state_t         r_state;
    fq_state_t         w_state_nxt;
    logic [AW-1:0]     r_pc;
    logic [AW-1:0]     w_pc_nxt;
    logic [AW-1:0]     r_addr;
    logic [AW-1:0]     w_addr_nxt;
    logic              w_push;
    logic              w_flush;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DW+31:0]    w_wdata;
    logic [DW+31:0]    w_head;

    // Request is a pure function of state: it rises on the cycle after issue
    // and stays up through the ack cycle, so the address is stable throughout.
    assign imem_req  = (r_state == FQ_WAIT) || (r_state == FQ_DRAIN);
    assign imem_addr = r_addr;

    assign w_wdata  = {imem_rdata, fq_next_pc(32'(r_addr))};
    assign w_pop    = id_valid & id_ready;
    assign id_valid = ~w_empty;
    assign id_ir    = w_head[DW+31:32];
    assign id_npc   = w_head[31:0];

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state <= FQ_IDLE;
            r_pc    <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_addr;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            FQ_IDLE: begin
                if (redirect) begin
                    w_flush     = 1'b1;
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = halt ? FQ_HALTED : FQ_IDLE;
                end else if (halt) begin
                    w_state_nxt = FQ_HALTED;
                end else if (!w_full) begin
                    // Occupancy before any same-cycle pop decides issue, so a
                    // push can never find the FIFO full.
                    w_addr_nxt  = r_pc;
                    w_state_nxt = FQ_WAIT;
                end
            end
            FQ_WAIT: begin
                if (redirect) begin
                    w_flush     = 1'b1;
                    w_pc_nxt    = redirect_pc;
                    // Without an ack the request cannot be withdrawn; drain it.
                    w_state_nxt = imem_ack ? FQ_IDLE : FQ_DRAIN;
                end else if (imem_ack) begin
                    w_push      = 1'b1;
                    w_pc_nxt    = r_addr + AW'(1);
                    w_state_nxt = halt ? FQ_HALTED : FQ_IDLE;
                end
            end
            FQ_DRAIN: begin
                if (redirect) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = redirect_pc;
                end
                if (imem_ack) begin
                    w_state_nxt = FQ_IDLE;
                end
            end
            FQ_HALTED: begin
                if (redirect) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = redirect_pc;
                end
                w_state_nxt = halt ? FQ_HALTED : FQ_IDLE;
            end
            default: w_state_nxt = FQ_IDLE;
        endcase
    end

    fq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DW + 32)
    ) u_fifo (
        .clk1  (clk1),
        .rst   (rst),
        .push  (w_push),
        .wdata (w_wdata),
        .pop   (w_pop),
        .flush (w_flush),
        .rdata (w_head),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue. A queue-based reference
//                model tracks FIFO contents, the outstanding request and the
//                halt condition; one compare process checks the DUT against
//                it every cycle. Directed phases pin the model with literal
//                expectations, followed by a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int DW    = 32;

    logic                   clk1 = 1'b0;
    logic                   rst;
    logic                   imem_req;
    logic [AW-1:0]          imem_addr;
    logic                   imem_ack;
    logic [DW-1:0]          imem_rdata;
    logic                   redirect;
    logic [AW-1:0]          redirect_pc;
    logic                   halt;
    logic                   id_valid;
    logic [DW-1:0]          id_ir;
    logic [31:0]            id_npc;
    logic                   id_ready;
    logic [$clog2(DEPTH):0] count;

    fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk1        (clk1),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .id_valid    (id_valid),
        .id_ir       (id_ir),
        .id_npc      (id_npc),
        .id_ready    (id_ready),
        .count       (count)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL timeout %s: event not seen within cycle budget", nm);
    endtask

    // ---------------- reference model ----------------
    logic [63:0] mq[$];        // {ir, npc} entries, front = head
    logic [63:0] pop_log[$];   // entries accepted by decode
    int          req_log[$];   // addresses of each new DUT request
    int          m_pc;
    int          m_addr;
    bit          m_out;        // a request is outstanding
    bit          m_disc;       // outstanding response must be discarded
    bit          m_halted;
    bit          chk_en = 1'b0;
    bit          prev_req = 1'b0;
    int          sz_b;
    bit          out_b;
    bit          do_iss;

    always @(posedge clk1 or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_pc     = 0;
            m_addr   = 0;
            m_out    = 1'b0;
            m_disc   = 1'b0;
            m_halted = 1'b0;
        end else begin
            sz_b   = mq.size();
            out_b  = m_out;
            do_iss = !out_b && !m_halted && !halt && !redirect && (sz_b < DEPTH);
            if (redirect) begin
                mq.delete();
                m_pc = int'(redirect_pc);
                if (out_b) begin
                    if (imem_ack) begin
                        m_out  = 1'b0;
                        m_disc = 1'b0;
                    end else begin
                        m_disc = 1'b1;
                    end
                end else begin
                    m_halted = halt;
                end
            end else begin
                if (sz_b != 0 && id_ready) begin
                    pop_log.push_back(mq[0]);
                    void'(mq.pop_front());
                end
                if (out_b) begin
                    if (imem_ack) begin
                        if (!m_disc) begin
                            mq.push_back({imem_rdata, 32'(m_addr + 1)});
                            m_pc     = (m_addr + 1) % (1 << AW);
                            m_halted = halt;
                        end
                        m_out  = 1'b0;
                        m_disc = 1'b0;
                    end
                end else begin
                    m_halted = halt;
                end
            end
            if (do_iss) begin
                m_out  = 1'b1;
                m_addr = m_pc;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk1) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (chk_en) begin
                chk("count", 64'(count), 64'(mq.size()));
                chk("id_valid", 64'(id_valid), 64'(mq.size() != 0));
                if (mq.size() != 0) begin
                    chk("id_ir", 64'(id_ir), 64'(mq[0][63:32]));
                    chk("id_npc", 64'(id_npc), 64'(mq[0][31:0]));
                end
                chk("imem_req", 64'(imem_req), 64'(m_out));
                if (m_out) chk("imem_addr", 64'(imem_addr), 64'(m_addr));
            end
            if (imem_req && !prev_req) req_log.push_back(int'(imem_addr));
            prev_req = imem_req;
        end
    end

    // ---------------- memory model ----------------
    logic [31:0] memw [1024];
    int          lat = 1;
    int          waitcnt = 0;
    bit          force_bad = 1'b0;

    task automatic mem_drive();
        if (rst) begin
            imem_ack = 1'b0;
            waitcnt  = 0;
        end else if (imem_req) begin
            if (waitcnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = force_bad ? 32'hDEADBEEF : memw[imem_addr];
                force_bad  = 1'b0;
                waitcnt    = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                waitcnt++;
            end
        end else begin
            imem_ack = 1'b0;
            waitcnt  = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk1);
        #1;
        mem_drive();
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] exp_ir [4];
    int  base, pb, pend;
    bit  ok;

    initial begin
        exp_ir[0] = 32'h2801000A;
        exp_ir[1] = 32'h28020014;
        exp_ir[2] = 32'h00221800;
        exp_ir[3] = 32'hFC000000;
        for (int i = 0; i < 1024; i++) memw[i] = $urandom;
        for (int i = 0; i < 4; i++) memw[i] = exp_ir[i];

        rst = 1'b1;
        imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0; redirect_pc = '0;
        halt = 1'b0; id_ready = 1'b0;
        repeat (3) @(negedge clk1);
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_imem_addr", 64'(imem_addr), 64'd0);
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_id_ir", 64'(id_ir), 64'd0);
        chk("rst_id_npc", 64'(id_npc), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Phase 1: in-order fetch of the first four words
        lat = 1; id_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (pop_log.size() >= 4) begin ok = 1; break; end
        end
        if (!ok) tmo("first_four");
        for (int i = 0; i < 4; i++) begin
            chk("seq_ir", 64'(pop_log[i][63:32]), 64'(exp_ir[i]));
            chk("seq_npc", 64'(pop_log[i][31:0]), 64'(i + 1));
            chk("seq_addr", 64'(req_log[i]), 64'(i));
        end

        // Phase 2: stall decode until full, then free exactly one slot
        id_ready = 1'b0;
        repeat (20) tick();
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_no_req", 64'(imem_req), 64'd0);
        base = req_log.size();
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        repeat (10) tick();
        chk("one_refill_req", 64'(req_log.size() - base), 64'd1);
        chk("refill_count", 64'(count), 64'(DEPTH));

        // Phase 3: redirect during WAIT, stale response is poisoned
        lat = 3; id_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (imem_req && !imem_ack) begin ok = 1; break; end
        end
        if (!ok) tmo("wait_for_req_p3");
        force_bad = 1'b1;
        redirect = 1'b1; redirect_pc = 10'h100;
        base = req_log.size(); pb = pop_log.size();
        tick();
        redirect = 1'b0;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (pop_log.size() > pb && req_log.size() > base) begin ok = 1; break; end
        end
        if (!ok) tmo("refetch_after_redirect");
        lat = 1;
        chk("redir_addr", 64'(req_log[base]), 64'h100);
        chk("redir_npc", 64'(pop_log[pb][31:0]), 64'h101);
        chk("redir_no_stale", 64'(pop_log[pb][63:32] == 32'hDEADBEEF), 64'd0);

        // Phase 4: redirect coinciding with ack and pop, two entries held
        id_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 10'h200;
        tick();
        redirect = 1'b0;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (count == 2 && imem_ack) begin ok = 1; break; end
        end
        if (!ok) tmo("two_entries_with_ack");
        id_ready = 1'b1; redirect = 1'b1; redirect_pc = 10'h155;
        base = req_log.size();
        tick();
        redirect = 1'b0; id_ready = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(id_valid), 64'd0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_log.size() > base) begin ok = 1; break; end
        end
        if (!ok) tmo("req_after_flush");
        chk("flush_next_addr", 64'(req_log[base]), 64'h155);

        // Phase 5: halt mid-WAIT
        lat = 3; id_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (imem_req && !imem_ack) begin ok = 1; break; end
        end
        if (!ok) tmo("wait_for_req_p5");
        halt = 1'b1; id_ready = 1'b0;
        pend = m_addr;
        base = req_log.size();
        repeat (15) tick();
        chk("halt_no_new_req", 64'(req_log.size()), 64'(base));
        chk("halt_req_low", 64'(imem_req), 64'd0);
        id_ready = 1'b1;
        repeat (10) tick();
        chk("halt_drained", 64'(count), 64'd0);
        halt = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_log.size() > base) begin ok = 1; break; end
        end
        if (!ok) tmo("resume_after_halt");
        chk("resume_addr", 64'(req_log[base]), 64'((pend + 1) % 1024));

        // Phase 6: fetch at the top of the address space wraps
        lat = 1; id_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 10'd1023;
        tick();
        redirect = 1'b0;
        base = req_log.size(); pb = pop_log.size();
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (req_log.size() >= base + 2 && pop_log.size() > pb) begin ok = 1; break; end
        end
        if (!ok) tmo("wrap_fetch");
        chk("wrap_addr_1023", 64'(req_log[base]), 64'd1023);
        chk("wrap_addr_0", 64'(req_log[base + 1]), 64'd0);
        chk("wrap_npc", 64'(pop_log[pb][31:0]), 64'd1024);
        chk("wrap_ir", 64'(pop_log[pb][63:32]), 64'(memw[1023]));

        // Phase 7: randomized traffic
        for (int i = 0; i < 400; i++) begin
            tick();
            id_ready    = 1'($urandom_range(0, 1));
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = AW'($urandom);
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            lat = $urandom_range(0, 3);
        end
        tick();
        redirect = 1'b0; halt = 1'b0; id_ready = 1'b1;
        repeat (10) tick();

        // Phase 8: asynchronous reset mid-WAIT
        lat = 3;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (imem_req && !imem_ack) begin ok = 1; break; end
        end
        if (!ok) tmo("wait_for_req_p8");
        rst = 1'b1;
        #1;
        chk("arst_imem_req", 64'(imem_req), 64'd0);
        chk("arst_imem_addr", 64'(imem_addr), 64'd0);
        chk("arst_id_valid", 64'(id_valid), 64'd0);
        chk("arst_id_ir", 64'(id_ir), 64'd0);
        chk("arst_id_npc", 64'(id_npc), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        lat = 1;
        base = req_log.size();
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_log.size() > base) begin ok = 1; break; end
        end
        if (!ok) tmo("req_after_reset");
        chk("post_rst_addr", 64'(req_log[base]), 64'd0);
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire
